// File: rtl/boreal_extract_sequencer.sv
// boreal_extract_sequencer
// Frame sequencer in front of an 8-channel weighted feature extractor. Collects one
// complete in-order frame of channel-tagged samples, replays it to the extractor on
// consecutive cycles starting at channel 0, then captures the extractor's X/Y result
// with a one-cycle strobe. Out-of-order frames are dropped so the extractor's own
// channel counter always sees whole frames.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   rst_i           synchronous active-high reset (shared with the extractor)
//   enable_i        1 = accept frames, 0 = drop any partial frame and stop accepting
//   s_valid_i       upstream sample valid
//   s_ready_o       sequencer can accept a sample this cycle
//   s_ch_i          channel tag of s_data_i
//   s_data_i        signed sample
//   ext_valid_o     sample strobe to the extractor
//   ext_sample_o    sample to the extractor, holds when ext_valid_o is low
//   ext_feat_x_i    extractor X feature
//   ext_feat_y_i    extractor Y feature
//   feat_valid_o    one-cycle pulse, feat_x_o/feat_y_o updated this cycle
//   feat_x_o        captured X feature
//   feat_y_o        captured Y feature
//   frame_cnt_o     completed frames, wraps
//   sync_err_cnt_o  frames dropped for bad channel order, saturates
//   busy_o          replaying a frame or waiting for the result
module boreal_extract_sequencer #(
    parameter int unsigned NumCh = 8,
    parameter int unsigned ChW   = 3,
    parameter int unsigned DataW = 16,
    parameter int unsigned ErrW  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [ChW-1:0]          s_ch_i,
    input  logic signed [DataW-1:0] s_data_i,
    output logic                    ext_valid_o,
    output logic signed [DataW-1:0] ext_sample_o,
    input  logic signed [DataW-1:0] ext_feat_x_i,
    input  logic signed [DataW-1:0] ext_feat_y_i,
    output logic                    feat_valid_o,
    output logic signed [DataW-1:0] feat_x_o,
    output logic signed [DataW-1:0] feat_y_o,
    output logic [15:0]             frame_cnt_o,
    output logic [ErrW-1:0]         sync_err_cnt_o,
    output logic                    busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StPlay = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [ChW-1:0] LastCh = ChW'(NumCh - 1);

    logic [1:0]             state_q, state_d;
    logic [ChW-1:0]         exp_q, exp_d;
    logic [ChW-1:0]         k_q, k_d;
    logic [ChW-1:0]         k_next;
    logic                   ext_valid_q, ext_valid_d;
    logic signed [DataW-1:0] ext_sample_q, ext_sample_d;
    logic                   feat_valid_q, feat_valid_d;
    logic signed [DataW-1:0] feat_x_q, feat_x_d;
    logic signed [DataW-1:0] feat_y_q, feat_y_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic [ErrW-1:0]        err_q, err_d;
    logic                   err_inc;
    logic                   buf_we;
    logic                   accept;

    logic signed [DataW-1:0] buf_q [NumCh];

    assign s_ready_o = enable_i & ((state_q == StIdle) | (state_q == StFill));
    assign accept    = s_valid_i & s_ready_o;
    assign k_next    = k_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        k_d          = k_q;
        ext_valid_d  = 1'b0;
        ext_sample_d = ext_sample_q;
        feat_valid_d = 1'b0;
        feat_x_d     = feat_x_q;
        feat_y_d     = feat_y_q;
        frame_cnt_d  = frame_cnt_q;
        err_inc      = 1'b0;
        buf_we       = 1'b0;

        case (state_q)
            StIdle: begin
                // Stray mid-frame samples while idle are dropped without counting an error.
                if (accept && (s_ch_i == '0)) begin
                    buf_we  = 1'b1;
                    exp_d   = ChW'(1);
                    state_d = StFill;
                end
            end
            StFill: begin
                if (!enable_i) begin
                    state_d = StIdle;
                    exp_d   = '0;
                end else if (accept) begin
                    if (s_ch_i == exp_q) begin
                        buf_we = 1'b1;
                        if (exp_q == LastCh) begin
                            // Launch the replay on the same edge that stores the last
                            // sample; channel 0 is already in the buffer.
                            state_d      = StPlay;
                            exp_d        = '0;
                            k_d          = '0;
                            ext_valid_d  = 1'b1;
                            ext_sample_d = buf_q[0];
                        end else begin
                            exp_d = exp_q + 1'b1;
                        end
                    end else if (s_ch_i == '0) begin
                        // A new frame start inside a frame: restart on it.
                        buf_we  = 1'b1;
                        exp_d   = ChW'(1);
                        err_inc = 1'b1;
                    end else begin
                        state_d = StIdle;
                        exp_d   = '0;
                        err_inc = 1'b1;
                    end
                end
            end
            StPlay: begin
                // enable_i is ignored so the extractor always sees a whole frame.
                if (k_q == LastCh) begin
                    state_d = StDone;
                end else begin
                    k_d          = k_next;
                    ext_valid_d  = 1'b1;
                    ext_sample_d = buf_q[k_next];
                end
            end
            StDone: begin
                feat_x_d     = ext_feat_x_i;
                feat_y_d     = ext_feat_y_i;
                feat_valid_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
                exp_d   = '0;
            end
        endcase

        err_d = err_q;
        if (err_inc && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            exp_q        <= '0;
            k_q          <= '0;
            ext_valid_q  <= 1'b0;
            ext_sample_q <= '0;
            feat_valid_q <= 1'b0;
            feat_x_q     <= '0;
            feat_y_q     <= '0;
            frame_cnt_q  <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            k_q          <= k_d;
            ext_valid_q  <= ext_valid_d;
            ext_sample_q <= ext_sample_d;
            feat_valid_q <= feat_valid_d;
            feat_x_q     <= feat_x_d;
            feat_y_q     <= feat_y_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
        end
    end

    // Frame buffer needs no reset: every slot is written before it is replayed.
    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            buf_q[s_ch_i] <= s_data_i;
        end
    end

    assign ext_valid_o    = ext_valid_q;
    assign ext_sample_o   = ext_sample_q;
    assign feat_valid_o   = feat_valid_q;
    assign feat_x_o       = feat_x_q;
    assign feat_y_o       = feat_y_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign sync_err_cnt_o = err_q;
    assign busy_o         = (state_q == StPlay) | (state_q == StDone);

endmodule

// File: tb/tb_boreal_extract_sequencer.sv
// Testbench for boreal_extract_sequencer: directed scenarios followed by random traffic,
// all checked every cycle against a timeline model of the frame sequencer.
module tb_boreal_extract_sequencer;

    localparam int MaxC = 8192;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [2:0]  s_ch_i;
    logic [15:0] s_data_i;
    logic        ext_valid_o;
    logic [15:0] ext_sample_o;
    logic [15:0] ext_feat_x_i;
    logic [15:0] ext_feat_y_i;
    logic        feat_valid_o;
    logic [15:0] feat_x_o;
    logic [15:0] feat_y_o;
    logic [15:0] frame_cnt_o;
    logic [7:0]  sync_err_cnt_o;
    logic        busy_o;

    boreal_extract_sequencer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .s_ch_i         (s_ch_i),
        .s_data_i       (s_data_i),
        .ext_valid_o    (ext_valid_o),
        .ext_sample_o   (ext_sample_o),
        .ext_feat_x_i   (ext_feat_x_i),
        .ext_feat_y_i   (ext_feat_y_i),
        .feat_valid_o   (feat_valid_o),
        .feat_x_o       (feat_x_o),
        .feat_y_o       (feat_y_o),
        .frame_cnt_o    (frame_cnt_o),
        .sync_err_cnt_o (sync_err_cnt_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Timeline model: a completed frame schedules its replay, busy window and result
    // strobe at fixed offsets from the cycle of its last accepted sample.
    bit          sev   [MaxC];
    logic [15:0] ses   [MaxC];
    bit          sbusy [MaxC];
    bit          sfv   [MaxC];
    logic [15:0] fxa   [MaxC];
    logic [15:0] fya   [MaxC];

    logic [15:0] frame [8];
    int          nfill    = 0;
    int          ready_at = 0;
    logic [15:0] m_es = '0;
    logic [15:0] m_fx = '0;
    logic [15:0] m_fy = '0;
    logic [15:0] m_fc = '0;
    int          m_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void bump_err();
        if (m_err < 255) m_err++;
    endfunction

    // One clock cycle: drive at the falling edge, check, update the model, cross posedge.
    task automatic run_cycle(input bit r, input bit en, input bit v, input int ch,
                             input logic [15:0] d);
        bit acc;
        bit exp_ready;
        if (cyc >= MaxC - 16) begin
            $display("FAIL timeline cyc=%0d got=overflow exp=within %0d", cyc, MaxC - 16);
            $fatal(1, "timeline overflow");
        end
        if (sev[cyc]) m_es = ses[cyc];
        if (sfv[cyc]) begin
            m_fx = fxa[cyc-1];
            m_fy = fya[cyc-1];
            m_fc = m_fc + 16'd1;
        end
        fxa[cyc] = 16'($urandom);
        fya[cyc] = 16'($urandom);
        rst_i        = r;
        enable_i     = en;
        s_valid_i    = v;
        s_ch_i       = 3'(ch);
        s_data_i     = d;
        ext_feat_x_i = fxa[cyc];
        ext_feat_y_i = fya[cyc];
        #1;
        exp_ready = en && (cyc >= ready_at);
        if (chk_en) begin
            check_eq("s_ready", 32'(s_ready_o), 32'(exp_ready));
            check_eq("ext_valid", 32'(ext_valid_o), 32'(sev[cyc]));
            check_eq("ext_sample", 32'(ext_sample_o), 32'(m_es));
            check_eq("feat_valid", 32'(feat_valid_o), 32'(sfv[cyc]));
            check_eq("feat_x", 32'(feat_x_o), 32'(m_fx));
            check_eq("feat_y", 32'(feat_y_o), 32'(m_fy));
            check_eq("frame_cnt", 32'(frame_cnt_o), 32'(m_fc));
            check_eq("sync_err_cnt", 32'(sync_err_cnt_o), 32'(m_err));
            check_eq("busy", 32'(busy_o), 32'(sbusy[cyc]));
        end
        if (r) begin
            for (int i = cyc + 1; i <= cyc + 12; i++) begin
                sev[i]   = 1'b0;
                sbusy[i] = 1'b0;
                sfv[i]   = 1'b0;
            end
            nfill    = 0;
            ready_at = cyc + 1;
            m_es  = '0;
            m_fx  = '0;
            m_fy  = '0;
            m_fc  = '0;
            m_err = 0;
        end else begin
            acc = v && exp_ready;
            if (!en) begin
                nfill = 0;
            end else if (acc) begin
                if (nfill == 0) begin
                    if (ch == 0) begin
                        frame[0] = d;
                        nfill = 1;
                    end
                end else if (ch == nfill) begin
                    frame[nfill] = d;
                    nfill++;
                    if (nfill == 8) begin
                        for (int k = 0; k < 8; k++) begin
                            sev[cyc+1+k] = 1'b1;
                            ses[cyc+1+k] = frame[k];
                        end
                        for (int k = 1; k <= 9; k++) sbusy[cyc+k] = 1'b1;
                        sfv[cyc+10] = 1'b1;
                        ready_at = cyc + 10;
                        nfill = 0;
                    end
                end else if (ch == 0) begin
                    frame[0] = d;
                    nfill = 1;
                    bump_err();
                end else begin
                    nfill = 0;
                    bump_err();
                end
            end
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b1, 1'b0, 0, 16'h0);
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int k = 0; k < 8; k++) run_cycle(1'b0, 1'b1, 1'b1, k, base + 16'(k));
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; s_valid_i = 1'b0; s_ch_i = '0; s_data_i = '0;
        ext_feat_x_i = '0; ext_feat_y_i = '0;
        @(negedge clk_i);
        run_cycle(1'b1, 1'b0, 1'b0, 0, 16'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 0, 16'h0);
        chk_en = 1'b1;
        idle(2);

        // Clean frame with data 1..8.
        send_frame(16'd1);
        idle(12);

        // Bad order 0,1,2,5 then a clean frame.
        run_cycle(1'b0, 1'b1, 1'b1, 0, 16'h10);
        run_cycle(1'b0, 1'b1, 1'b1, 1, 16'h11);
        run_cycle(1'b0, 1'b1, 1'b1, 2, 16'h12);
        run_cycle(1'b0, 1'b1, 1'b1, 5, 16'h15);
        idle(2);
        send_frame(16'h100);
        idle(12);

        // 0,1,2 then a restart on 0 and a full frame.
        run_cycle(1'b0, 1'b1, 1'b1, 0, 16'hAA0);
        run_cycle(1'b0, 1'b1, 1'b1, 1, 16'hAA1);
        run_cycle(1'b0, 1'b1, 1'b1, 2, 16'hAA2);
        send_frame(16'h200);
        idle(12);

        // s_valid held through replay, enable dropped mid-replay.
        send_frame(16'h8000);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b1, i, 16'($urandom));
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 1'b1, i, 16'($urandom));
        idle(3);

        // enable low after 4 accepts, then stray channel 3 samples in idle.
        for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b1, 1'b1, k, 16'h300 + 16'(k));
        run_cycle(1'b0, 1'b0, 1'b0, 0, 16'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 0, 16'h0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b1, 3, 16'h333);
        idle(2);

        // Saturate the error counter, then reset on the 4th replay cycle.
        for (int i = 0; i < 260; i++) begin
            run_cycle(1'b0, 1'b1, 1'b1, 0, 16'h0);
            run_cycle(1'b0, 1'b1, 1'b1, 5, 16'h5);
        end
        send_frame(16'h400);
        idle(3);
        run_cycle(1'b1, 1'b1, 1'b0, 0, 16'h0);
        idle(4);
        send_frame(16'h500);
        idle(12);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, en, v;
            int ch, p;
            r  = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 39) != 0);
            v  = ($urandom_range(0, 3) != 0);
            p  = $urandom_range(0, 19);
            if (p < 16)      ch = nfill;
            else if (p < 18) ch = 0;
            else             ch = $urandom_range(0, 7);
            run_cycle(r, en, v, ch, 16'($urandom));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
